motor_dense_seq_acc: RTL and testbench
======================================

Name: motor_dense_seq_acc

Overview:
- Sequential dense (fully connected) layer for the motor network, ap_fixed<32,8> arithmetic: 32 bits, 24 fractional bits, two's complement.
- Sits directly upstream of the 3-wide ReLU stage and produces its three pre-activation values.
- Consumes one input feature per accepted beat and runs 3 parallel MACs against internally stored weights.
- Presents the three results, plus bias, as one registered output frame with a valid/ready handshake.

Parameters:
- N_IN, 8, input features per frame (2..64).
- N_OUT, 3, output neurons; fixed at 3 to match the downstream ReLU.
- CFG_AW, 8, config address width; must satisfy 2^CFG_AW >= 3*N_IN+3.

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst  in  1  asynchronous, active-high reset.
- in_data  in  32  input feature, ap_fixed<32,8>.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept in_data.
- out_data_0  out  32  neuron 0 result; feeds ReLU p_read.
- out_data_1  out  32  neuron 1 result; feeds ReLU p_read7.
- out_data_2  out  32  neuron 2 result; feeds ReLU p_read8.
- out_valid  out  1  output frame valid.
- out_ready  in  1  consumer accepts the frame.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  CFG_AW  address j*N_IN+i = weight W[j][i]; 3*N_IN+j = bias B[j].
- cfg_data  in  32  weight/bias value, ap_fixed<32,8>.
- cfg_err  out  1  sticky flag: a config write was dropped.
- busy  out  1  high in ACC or OUT.

Behaviour:
- Reset (async, ap_rst=1):
  - State=IDLE, input counter=0, accumulators=0.
  - All weights and biases=0; out_data_0..2=0; out_valid=0; cfg_err=0; busy=0.
  - in_ready goes to 1 on the first clock after reset deasserts.
  - Reset mid-frame discards the partial frame.
- States:
  - IDLE: in_ready=1. An accepted beat (in_valid & in_ready) with counter=0 sets acc[j] = (B[j]<<24) + W[j][0]*x, then counter=1 and go to ACC. If N_IN reached, go directly to OUT.
  - ACC: in_ready=1. Each accepted beat does acc[j] += W[j][cnt]*x and cnt++. On the beat with cnt=N_IN-1, go to OUT. in_valid low stalls with no state change.
  - OUT: in_ready=0, out_valid=1. out_data_j is stable until out_ready=1. The transfer cycle returns to IDLE and clears cnt.
- Latency: out_valid rises on the clock edge after the last input is accepted. Minimum frame period is N_IN+1 cycles.
- Arithmetic:
  - Products are a full 64-bit signed result (48 fraction bits).
  - Accumulators are 64+ceil(log2(N_IN+1)) bits signed; no intermediate overflow.
  - Output = acc[55:24]: arithmetic truncation toward −inf, wrap on overflow (AP_TRN/AP_WRAP).
  - Output registers load on the transition into OUT.
- Config port:
  - cfg_we is honoured only in IDLE with cnt=0 and no in_valid accepted in the same cycle.
  - Otherwise the write is dropped and cfg_err is set; cfg_err is cleared only by reset.
  - Addresses >= 3*N_IN+3 are dropped and also set cfg_err.
  - A write in IDLE takes effect for the next frame's first beat, even if that beat arrives the following cycle.
- Simultaneous cfg_we and accepted input in IDLE: the input wins, the write is dropped, and cfg_err=1.
- out_valid must never drop without an out_ready handshake, except on reset.

Optional Feature:
- MOTOR_DENSE_SAT_EN defined: on output quantisation, if acc exceeds the representable range, saturate (AP_SAT).
  - Positive overflow → 0x7FFFFFFF.
  - Negative overflow → 0x80000000.
  - Truncation rule is unchanged.
- Undefined: wrap behaviour as above. No port or latency difference.

Test Plan:
- Setup: N_IN=4; all W=1.0 (0x01000000); B=0.5 (0x00800000). Inputs 1.0, 2.0, −0.5, 0.25 back-to-back → out_valid one cycle after the 4th beat; all outputs 0x03400000 (3.25).
- Overflow: W[0][*]=100.0 (0x64000000), B=0. Inputs 1.0, 1.0, 0, 0 → out_data_0=0xC8000000 (−56, wrapped). With MOTOR_DENSE_SAT_EN → 0x7FFFFFFF.
- Truncation: W=1.0, single nonzero input 0xFFFFFFFF (−2^-24), others 0, B=0 → 0xFFFFFFFF (no round to 0).
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → outputs and out_valid stable, in_ready=0. out_ready=1 → next cycle out_valid=0, in_ready=1.
- Reset mid-frame: assert ap_rst after 2 beats → outputs 0, weights 0. A reload plus a full frame of 1.0 inputs gives the bias-only-plus-sum result, with no residue from the aborted frame.
- Config write during ACC → write dropped (next frame uses the old weight), cfg_err=1 until reset.

Source files
------------

// File: rtl/motor_dense_seq_acc_if.sv
// ============================================================================
// Module   : motor_dense_seq_acc_if
// Purpose  : Stream-in, frame-out and config bus of the motor dense layer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface motor_dense_seq_acc_if #(
    parameter int CFG_AW = 8
);
    logic [31:0]       in_data;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       out_data_0;
    logic [31:0]       out_data_1;
    logic [31:0]       out_data_2;
    logic              out_valid;
    logic              out_ready;
    logic              cfg_we;
    logic [CFG_AW-1:0] cfg_addr;
    logic [31:0]       cfg_data;
    logic              cfg_err;
    logic              busy;

    modport master (
        output in_data, in_valid, out_ready, cfg_we, cfg_addr, cfg_data,
        input  in_ready, out_data_0, out_data_1, out_data_2, out_valid,
               cfg_err, busy
    );

    modport slave (
        input  in_data, in_valid, out_ready, cfg_we, cfg_addr, cfg_data,
        output in_ready, out_data_0, out_data_1, out_data_2, out_valid,
               cfg_err, busy
    );
endinterface

`default_nettype wire

// File: rtl/motor_dense_seq_acc.sv
// ============================================================================
// Module   : motor_dense_seq_acc
// Purpose  : Sequential 3-neuron dense layer, ap_fixed<32,8>, one feature/beat.
//            Define MOTOR_DENSE_SAT_EN to saturate instead of wrap on output.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module motor_dense_seq_acc #(
    parameter int N_IN   = 8,
    parameter int N_OUT  = 3,
    parameter int CFG_AW = 8
) (
    input  wire logic                 ap_clk,
    input  wire logic                 ap_rst,
    motor_dense_seq_acc_if.slave      bus
);
    localparam int ACC_W = 64 + $clog2(N_IN + 1);
    localparam int CNT_W = $clog2(N_IN + 1);
    localparam int N_W   = 3 * N_IN;
    localparam int N_CFG = 3 * N_IN + 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic                    started_q;
    logic                    cfg_err_q;
    logic signed [31:0]      w_q   [N_W];
    logic signed [31:0]      b_q   [N_OUT];
    logic signed [ACC_W-1:0] acc_q [N_OUT];
    logic signed [ACC_W-1:0] acc_d [N_OUT];
    logic [31:0]             out_q [N_OUT];

    logic in_ready, out_valid, busy;
    logic accept, last, cfg_ok;

    assign accept = bus.in_valid & in_ready;
    assign last   = (cnt_q == CNT_W'(N_IN - 1));
    assign cfg_ok = (state_q == S_IDLE) && (cnt_q == '0) && !accept &&
                    (int'(bus.cfg_addr) < N_CFG);

    // Output quantisation keeps acc[55:24]: floor truncation of 24 LSBs.
    function automatic logic [31:0] quant(input logic signed [ACC_W-1:0] a);
`ifdef MOTOR_DENSE_SAT_EN
        if ((&a[ACC_W-1:55]) || !(|a[ACC_W-1:55]))
            return a[55:24];
        else if (a[ACC_W-1])
            return 32'h8000_0000;
        else
            return 32'h7FFF_FFFF;
`else
        return a[55:24];
`endif
    endfunction

    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            logic signed [63:0]      prod;
            logic signed [ACC_W-1:0] base;
            prod = w_q[j * N_IN + int'(cnt_q)] * $signed(bus.in_data);
            if (cnt_q == '0)
                base = {{(ACC_W-56){b_q[j][31]}}, b_q[j], 24'd0};
            else
                base = acc_q[j];
            acc_d[j] = base + {{(ACC_W-64){prod[63]}}, prod};
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = last ? S_OUT : S_ACC;
            S_ACC:   if (accept && last) state_d = S_OUT;
            S_OUT:   if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            S_IDLE:  in_ready = started_q;
            S_ACC:   begin in_ready = 1'b1; busy = 1'b1; end
            S_OUT:   begin out_valid = 1'b1; busy = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            cnt_q     <= '0;
            started_q <= 1'b0;
            cfg_err_q <= 1'b0;
            for (int i = 0; i < N_W; i++) w_q[i] <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                b_q[j]   <= '0;
                acc_q[j] <= '0;
                out_q[j] <= '0;
            end
        end else begin
            started_q <= 1'b1;
            if (accept) begin
                for (int j = 0; j < N_OUT; j++) acc_q[j] <= acc_d[j];
                if (last) begin
                    cnt_q <= '0;
                    for (int j = 0; j < N_OUT; j++) out_q[j] <= quant(acc_d[j]);
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            if (bus.cfg_we) begin
                if (!cfg_ok)
                    cfg_err_q <= 1'b1;
                else if (int'(bus.cfg_addr) < N_W)
                    w_q[int'(bus.cfg_addr)] <= bus.cfg_data;
                else
                    b_q[int'(bus.cfg_addr) - N_W] <= bus.cfg_data;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.busy       = busy;
    assign bus.cfg_err    = cfg_err_q;
    assign bus.out_data_0 = out_q[0];
    assign bus.out_data_1 = out_q[1];
    assign bus.out_data_2 = out_q[2];
endmodule

`default_nettype wire

// File: tb/tb_motor_dense_seq_acc.sv
// ============================================================================
// Module   : tb_motor_dense_seq_acc
// Purpose  : Directed scoreboard bench for motor_dense_seq_acc with N_IN=4.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_motor_dense_seq_acc;
    localparam int N_IN = 4;
    localparam logic [31:0] ONE  = 32'h0100_0000;
    localparam logic [31:0] HALF = 32'h0080_0000;

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [95:0] exp_q [$];

    motor_dense_seq_acc_if #(.CFG_AW(8)) bus ();

    motor_dense_seq_acc #(.N_IN(N_IN), .N_OUT(3), .CFG_AW(8)) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected frame per completed output handshake.
    always @(negedge ap_clk) begin
        if (!ap_rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_frame", 32'd1, 32'd0);
            end else begin
                logic [95:0] e;
                e = exp_q.pop_front();
                chk("out_data_0", bus.out_data_0, e[95:64]);
                chk("out_data_1", bus.out_data_1, e[63:32]);
                chk("out_data_2", bus.out_data_2, e[31:0]);
            end
        end
    end

    task automatic cfg_write(input int addr, input logic [31:0] data);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 8'(addr);
        bus.cfg_data = data;
        @(posedge ap_clk); #1;
        bus.cfg_we   = 1'b0;
    endtask

    task automatic load_all(input logic [31:0] w, input logic [31:0] b);
        for (int a = 0; a < 3 * N_IN; a++) cfg_write(a, w);
        for (int j = 0; j < 3; j++) cfg_write(3 * N_IN + j, b);
    endtask

    task automatic send_beat(input logic [31:0] x);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = x;
        n = 0;
        @(negedge ap_clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge ap_clk);
            n++;
        end
        if (!bus.in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
        @(posedge ap_clk); #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.out_valid && n < 50) begin
            @(posedge ap_clk); #1;
            n++;
        end
        if (bus.out_valid) chk("out_valid_stuck", 32'd1, 32'd0);
    endtask

    task automatic frame(input logic [31:0] x0, x1, x2, x3, input logic [95:0] e);
        exp_q.push_back(e);
        send_beat(x0);
        send_beat(x1);
        send_beat(x2);
        send_beat(x3);
        bus.in_valid = 1'b0;
        chk("latency_out_valid", {31'd0, bus.out_valid}, 32'd1);
        wait_idle();
    endtask

    initial begin
        logic [31:0] sat0;
        int n;
`ifdef MOTOR_DENSE_SAT_EN
        sat0 = 32'h7FFF_FFFF;
`else
        sat0 = 32'hC800_0000;
`endif
        bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
        #12;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, bus.in_ready}, 32'd0);
        chk("rst_cfg_err",   {31'd0, bus.cfg_err}, 32'd0);
        chk("rst_busy",      {31'd0, bus.busy}, 32'd0);
        chk("rst_out0",      bus.out_data_0, 32'd0);
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        chk("in_ready_before_clk", {31'd0, bus.in_ready}, 32'd0);
        @(posedge ap_clk); #1;
        chk("in_ready_after_clk", {31'd0, bus.in_ready}, 32'd1);

        // Basic frame: bias 0.5 + 1 + 2 - 0.5 + 0.25 = 3.25
        load_all(ONE, HALF);
        frame(32'h0100_0000, 32'h0200_0000, 32'hFF80_0000, 32'h0040_0000,
              {32'h0340_0000, 32'h0340_0000, 32'h0340_0000});

        // Overflow on neuron 0: 100 + 100 = 200 -> wraps to -56
        for (int i = 0; i < N_IN; i++) cfg_write(i, 32'h6400_0000);
        for (int j = 0; j < 3; j++) cfg_write(3 * N_IN + j, 32'h0);
        frame(ONE, ONE, 32'h0, 32'h0, {sat0, 32'h0200_0000, 32'h0200_0000});

        // Truncation toward -inf of -2^-24 * 1.0
        for (int i = 0; i < N_IN; i++) cfg_write(i, ONE);
        frame(32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0,
              {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
        chk("cfg_err_clean", {31'd0, bus.cfg_err}, 32'd0);

        cfg_write(3 * N_IN + 3, 32'h1234_5678);
        chk("cfg_err_bad_addr", {31'd0, bus.cfg_err}, 32'd1);

        // Backpressure: 0.5 + 4*1.0 = 4.5
        for (int j = 0; j < 3; j++) cfg_write(3 * N_IN + j, HALF);
        bus.out_ready = 1'b0;
        exp_q.push_back({32'h0480_0000, 32'h0480_0000, 32'h0480_0000});
        for (int k = 0; k < N_IN; k++) send_beat(ONE);
        bus.in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_in_ready",  {31'd0, bus.in_ready}, 32'd0);
            chk("bp_out1",      bus.out_data_1, 32'h0480_0000);
            @(posedge ap_clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge ap_clk); #1;
        chk("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);

        // Reset after two beats of a frame
        send_beat(32'h0700_0000);
        send_beat(32'h0700_0000);
        bus.in_valid = 1'b0;
        ap_rst = 1'b1;
        #1;
        chk("mid_rst_out0",  bus.out_data_0, 32'd0);
        chk("mid_rst_out2",  bus.out_data_2, 32'd0);
        chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_err",   {31'd0, bus.cfg_err}, 32'd0);
        chk("mid_rst_busy",  {31'd0, bus.busy}, 32'd0);
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        @(posedge ap_clk); #1;
        frame(ONE, ONE, ONE, ONE, {32'h0, 32'h0, 32'h0});
        load_all(ONE, HALF);
        frame(ONE, ONE, ONE, ONE, {32'h0480_0000, 32'h0480_0000, 32'h0480_0000});

        // Config write during ACC must be dropped
        exp_q.push_back({32'h0480_0000, 32'h0480_0000, 32'h0480_0000});
        send_beat(ONE);
        bus.in_valid = 1'b0;
        cfg_write(1, 32'h0200_0000);
        chk("cfg_err_acc", {31'd0, bus.cfg_err}, 32'd1);
        for (int k = 1; k < N_IN; k++) send_beat(ONE);
        bus.in_valid = 1'b0;
        wait_idle();

        // Config write coinciding with an accepted first beat is dropped
        exp_q.push_back({32'h0480_0000, 32'h0480_0000, 32'h0480_0000});
        bus.cfg_we = 1'b1; bus.cfg_addr = 8'(N_IN); bus.cfg_data = 32'h0300_0000;
        send_beat(ONE);
        bus.cfg_we = 1'b0;
        for (int k = 1; k < N_IN; k++) send_beat(ONE);
        bus.in_valid = 1'b0;
        wait_idle();
        chk("cfg_err_sticky", {31'd0, bus.cfg_err}, 32'd1);

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge ap_clk); #1;
            n++;
        end
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
